// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the I/D memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned FAULT_TY_W = 2;

  typedef logic [XLEN-1:0]       Addr;
  typedef logic [XLEN-1:0]       UIntX;
  typedef logic [FAULT_TY_W-1:0] FaultTy;

  localparam Addr  ADDR_ZERO = '0;
  localparam UIntX ZBIT_32   = '0;

  // Arbiter transaction state.
  typedef enum logic [1:0] {
    StIdle,   // nothing outstanding
    StWaitI,  // fetch outstanding
    StWaitD,  // LSU access outstanding
    StDrain   // killed fetch outstanding, response will be dropped
  } arb_state_e;

  // Which requester owns the memory port for the current issue.
  typedef enum logic {
    OwnerI,
    OwnerD
  } mem_owner_e;

  // Consecutive-D-grant counter, saturating at 15.
  typedef logic [3:0] streak_t;
  localparam streak_t STREAK_MAX = 4'hF;

  function automatic streak_t streak_sat_inc(streak_t v);
    return (v == STREAK_MAX) ? v : v + streak_t'(1);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection between fetch and LSU plus the anti-starvation D streak counter.
module mem_arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic can_issue,
  input  logic i_req_valid,
  input  logic d_req_valid,
  input  logic mem_req_ready,
  output logic grant_i,
  output logic grant_d,
  output logic req_valid,
  output logic xfer
);

  localparam streak_t Limit = streak_t'(STARVE_LIMIT);

  streak_t d_streak_q, d_streak_d;

  // D wins by default; I wins once D has been granted Limit times in a row while I waited.
  always_comb begin
    grant_i   = can_issue & i_req_valid & (~d_req_valid | (d_streak_q >= Limit));
    grant_d   = can_issue & d_req_valid & ~grant_i;
    req_valid = can_issue & (i_req_valid | d_req_valid);
    xfer      = req_valid & mem_req_ready;
  end

  // Count D transfers that happened while I was waiting; anything else clears the streak.
  always_comb begin
    d_streak_d = d_streak_q;
    if (xfer) begin
      if (grant_d && i_req_valid) begin
        d_streak_d = streak_sat_inc(d_streak_q);
      end else begin
        d_streak_d = '0;
      end
    end
  end

  // Streak register.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_streak_q <= '0;
    end else begin
      d_streak_q <= d_streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch queue (I) and the LSU (D), one
// transaction in flight, with fetch-kill draining of orphaned responses.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ERRTY_WIDTH  = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  // Fetch side
  input  logic                   i_req_valid,
  output logic                   i_req_ready,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  input  logic                   i_kill,
  output logic                   i_resp_valid,
  output logic [DATA_WIDTH-1:0]  i_resp_rdata,
  output logic                   i_resp_error,
  output logic [ERRTY_WIDTH-1:0] i_resp_errty,
  // LSU side
  input  logic                   d_req_valid,
  output logic                   d_req_ready,
  input  logic [ADDR_WIDTH-1:0]  d_req_addr,
  input  logic                   d_req_wen,
  input  logic [DATA_WIDTH-1:0]  d_req_wdata,
  output logic                   d_resp_valid,
  output logic [DATA_WIDTH-1:0]  d_resp_rdata,
  output logic                   d_resp_error,
  output logic [ERRTY_WIDTH-1:0] d_resp_errty,
  // Memory side
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [ADDR_WIDTH-1:0]  mem_req_addr,
  output logic                   mem_req_wen,
  output logic [DATA_WIDTH-1:0]  mem_req_wdata,
  input  logic                   mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]  mem_resp_rdata,
  input  logic                   mem_resp_error,
  input  logic [ERRTY_WIDTH-1:0] mem_resp_errty
);

  arb_state_e state_q, state_d;
  logic       can_issue;
  logic       grant_i, grant_d, req_valid, xfer;
  mem_owner_e owner;

  // A response closes the current transaction, so a new one may issue in that same cycle.
  assign can_issue = (state_q == StIdle) | mem_resp_valid;

  mem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk           (clk),
    .reset         (reset),
    .can_issue     (can_issue),
    .i_req_valid   (i_req_valid),
    .d_req_valid   (d_req_valid),
    .mem_req_ready (mem_req_ready),
    .grant_i       (grant_i),
    .grant_d       (grant_d),
    .req_valid     (req_valid),
    .xfer          (xfer)
  );

  assign owner = grant_i ? OwnerI : OwnerD;

  // Request path: mux the granted side onto the memory port; fetches never write.
  always_comb begin
    mem_req_valid = req_valid;
    mem_req_addr  = ADDR_WIDTH'(ADDR_ZERO);
    mem_req_wen   = 1'b0;
    mem_req_wdata = DATA_WIDTH'(ZBIT_32);
    if (req_valid) begin
      unique case (owner)
        OwnerI: begin
          mem_req_addr = i_req_addr;
        end
        OwnerD: begin
          mem_req_addr  = d_req_addr;
          mem_req_wen   = d_req_wen;
          mem_req_wdata = d_req_wdata;
        end
      endcase
    end
    i_req_ready = grant_i & mem_req_ready;
    d_req_ready = grant_d & mem_req_ready;
  end

  // Response routing: zero-latency pass-through, valid steered by the owning state.
  always_comb begin
    i_resp_valid = mem_resp_valid & (state_q == StWaitI) & ~i_kill;
    d_resp_valid = mem_resp_valid & (state_q == StWaitD);
    i_resp_rdata = mem_resp_rdata;
    i_resp_error = mem_resp_error;
    i_resp_errty = mem_resp_errty;
    d_resp_rdata = mem_resp_rdata;
    d_resp_error = mem_resp_error;
    d_resp_errty = mem_resp_errty;
  end

  // Next state: a new issue wins, then response completion, then a fetch kill.
  always_comb begin
    state_d = state_q;
    if (xfer) begin
      state_d = grant_i ? StWaitI : StWaitD;
    end else begin
      unique case (state_q)
        StIdle: state_d = StIdle;
        StWaitI: begin
          if (mem_resp_valid) begin
            state_d = StIdle;
          end else if (i_kill) begin
            state_d = StDrain;
          end
        end
        StWaitD: begin
          if (mem_resp_valid) state_d = StIdle;
        end
        StDrain: begin
          if (mem_resp_valid) state_d = StIdle;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DEBUG
  // A response with nothing outstanding is a memory-side protocol violation.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(state_q == StIdle && mem_resp_valid))
        else $error("mem_resp_valid while idle");
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int EW    = 2;
  localparam int LIMIT = 4;

  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;
  localparam int OWN_DEAD = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req_valid, i_req_ready, i_kill, i_resp_valid, i_resp_error;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_resp_rdata;
  logic [EW-1:0] i_resp_errty;
  logic          d_req_valid, d_req_ready, d_req_wen, d_resp_valid, d_resp_error;
  logic [AW-1:0] d_req_addr;
  logic [DW-1:0] d_req_wdata, d_resp_rdata;
  logic [EW-1:0] d_resp_errty;
  logic          mem_req_valid, mem_req_ready, mem_req_wen;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_resp_valid, mem_resp_error;
  logic [DW-1:0] mem_resp_rdata;
  logic [EW-1:0] mem_resp_errty;

  mem_port_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .ERRTY_WIDTH  (EW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .i_req_valid    (i_req_valid),
    .i_req_ready    (i_req_ready),
    .i_req_addr     (i_req_addr),
    .i_kill         (i_kill),
    .i_resp_valid   (i_resp_valid),
    .i_resp_rdata   (i_resp_rdata),
    .i_resp_error   (i_resp_error),
    .i_resp_errty   (i_resp_errty),
    .d_req_valid    (d_req_valid),
    .d_req_ready    (d_req_ready),
    .d_req_addr     (d_req_addr),
    .d_req_wen      (d_req_wen),
    .d_req_wdata    (d_req_wdata),
    .d_resp_valid   (d_resp_valid),
    .d_resp_rdata   (d_resp_rdata),
    .d_resp_error   (d_resp_error),
    .d_resp_errty   (d_resp_errty),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .mem_resp_error (mem_resp_error),
    .mem_resp_errty (mem_resp_errty)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the outstanding transaction and the D streak.
  int owner  = OWN_NONE;
  int streak = 0;
  // Memory model: cycles until the pending response (-1 = none) and its payload.
  int            resp_cnt = -1;
  logic [DW-1:0] pend_rdata;
  logic          pend_err;
  logic [EW-1:0] pend_errty;
  // Payload and latency the memory will use for the next accepted request.
  int            next_lat = 1;
  logic [DW-1:0] next_rdata = '0;
  logic          next_err = 1'b0;
  logic [EW-1:0] next_errty = '0;

  // Values observed in the most recent cycle.
  logic          last_i_ready, last_d_ready, last_mvalid, last_wen;
  logic          last_i_resp_valid, last_d_resp_valid, last_d_err;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata, last_i_rdata;
  logic [EW-1:0] last_d_errty;
  logic          saw_i_resp;
  bit            grant_log[$];  // 1 = I granted, 0 = D granted

  bit exp_order2[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  bit exp_order6[5]  = '{0, 0, 0, 0, 1};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present the memory response, check all outputs, advance the model.
  task automatic run_cycle();
    logic resp, can_issue, gi, gd, exp_mvalid;
    resp = (resp_cnt == 0);
    mem_resp_valid = resp;
    if (resp) begin
      mem_resp_rdata = pend_rdata;
      mem_resp_error = pend_err;
      mem_resp_errty = pend_errty;
    end else begin
      mem_resp_rdata = $urandom();
      mem_resp_error = 1'($urandom_range(0, 1));
      mem_resp_errty = EW'($urandom_range(0, 3));
    end
    #2;
    can_issue  = (owner == OWN_NONE) || resp;
    gi         = can_issue && i_req_valid && (!d_req_valid || streak >= LIMIT);
    gd         = can_issue && d_req_valid && !gi;
    exp_mvalid = can_issue && (i_req_valid || d_req_valid);
    check("mem_req_valid", 64'(mem_req_valid), 64'(exp_mvalid));
    check("i_req_ready", 64'(i_req_ready), 64'(gi && mem_req_ready));
    check("d_req_ready", 64'(d_req_ready), 64'(gd && mem_req_ready));
    if (exp_mvalid) begin
      check("mem_req_addr", 64'(mem_req_addr), 64'(gi ? i_req_addr : d_req_addr));
      check("mem_req_wen", 64'(mem_req_wen), 64'(gi ? 1'b0 : d_req_wen));
      check("mem_req_wdata", 64'(mem_req_wdata), 64'(gi ? 32'h0 : d_req_wdata));
    end
    check("i_resp_valid", 64'(i_resp_valid), 64'(resp && owner == OWN_I && !i_kill));
    check("d_resp_valid", 64'(d_resp_valid), 64'(resp && owner == OWN_D));
    check("i_resp_fanout", 64'({i_resp_rdata, i_resp_error, i_resp_errty}),
          64'({mem_resp_rdata, mem_resp_error, mem_resp_errty}));
    check("d_resp_fanout", 64'({d_resp_rdata, d_resp_error, d_resp_errty}),
          64'({mem_resp_rdata, mem_resp_error, mem_resp_errty}));
    last_i_ready      = i_req_ready;
    last_d_ready      = d_req_ready;
    last_mvalid       = mem_req_valid;
    last_addr         = mem_req_addr;
    last_wen          = mem_req_wen;
    last_wdata        = mem_req_wdata;
    last_i_resp_valid = i_resp_valid;
    last_i_rdata      = i_resp_rdata;
    last_d_resp_valid = d_resp_valid;
    last_d_err        = d_resp_error;
    last_d_errty      = d_resp_errty;
    if (i_resp_valid) saw_i_resp = 1'b1;
    if (mem_req_valid && mem_req_ready) grant_log.push_back(i_req_ready);
    // Advance the model.
    if (exp_mvalid && mem_req_ready) begin
      owner      = gi ? OWN_I : OWN_D;
      streak     = (gd && i_req_valid) ? ((streak < 15) ? streak + 1 : 15) : 0;
      resp_cnt   = next_lat - 1;
      pend_rdata = next_rdata;
      pend_err   = next_err;
      pend_errty = next_errty;
    end else if (resp) begin
      owner    = OWN_NONE;
      resp_cnt = -1;
    end else begin
      if (owner == OWN_I && i_kill) owner = OWN_DEAD;
      if (resp_cnt > 0) resp_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    i_req_valid    = 1'b0;
    i_req_addr     = '0;
    i_kill         = 1'b0;
    d_req_valid    = 1'b0;
    d_req_addr     = '0;
    d_req_wen      = 1'b0;
    d_req_wdata    = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    mem_resp_error = 1'b0;
    mem_resp_errty = '0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    owner    = OWN_NONE;
    streak   = 0;
    resp_cnt = -1;
  endtask

  initial begin
    do_reset();

    // Reset state: nothing ready, nothing valid.
    run_cycle();
    check("rst_i_ready", 64'(last_i_ready), 64'(0));
    check("rst_mem_req_valid", 64'(last_mvalid), 64'(0));

    // 1. Fetch only, response two cycles after accept.
    mem_req_ready = 1'b1;
    i_req_valid = 1'b1; i_req_addr = 32'h100;
    next_lat = 2; next_rdata = 32'h0000_0013; next_err = 1'b0; next_errty = '0;
    run_cycle();
    check("t1_i_ready", 64'(last_i_ready), 64'(1));
    check("t1_addr", 64'(last_addr), 64'(32'h100));
    i_req_valid = 1'b0;
    run_cycle();
    run_cycle();
    check("t1_i_resp_valid", 64'(last_i_resp_valid), 64'(1));
    check("t1_i_rdata", 64'(last_i_rdata), 64'(32'h13));
    check("t1_d_resp_valid", 64'(last_d_resp_valid), 64'(0));
    d_req_valid = 1'b1; d_req_addr = 32'h104; next_lat = 1;
    run_cycle();
    check("t1_idle_after", 64'(last_d_ready), 64'(1));
    d_req_valid = 1'b0;
    run_cycle();

    // 2. Both requesting continuously: four D grants then one I.
    grant_log.delete();
    i_req_valid = 1'b1; i_req_addr = 32'h180;
    d_req_valid = 1'b1; d_req_addr = 32'h190;
    next_lat = 1;
    repeat (10) run_cycle();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    run_cycle();
    check("t2_grant_count", 64'(grant_log.size()), 64'(10));
    for (int k = 0; k < 10 && k < grant_log.size(); k++) begin
      check($sformatf("t2_grant_order[%0d]", k), 64'(grant_log[k]), 64'(exp_order2[k]));
    end

    // 3. Kill the outstanding fetch; its response must be dropped.
    saw_i_resp = 1'b0;
    i_req_valid = 1'b1; i_req_addr = 32'h200;
    next_lat = 4; next_rdata = 32'hDEAD_BEEF;
    run_cycle();
    i_req_valid = 1'b0; i_kill = 1'b1;
    run_cycle();
    i_kill = 1'b0;
    d_req_valid = 1'b1; d_req_addr = 32'h400; d_req_wen = 1'b0;
    next_lat = 1; next_rdata = 32'h0000_1234;
    run_cycle();
    check("t3_drain_hold_a", 64'(last_d_ready), 64'(0));
    run_cycle();
    check("t3_drain_hold_b", 64'(last_d_ready), 64'(0));
    run_cycle();
    check("t3_d_accept_on_resp", 64'(last_d_ready), 64'(1));
    check("t3_no_i_resp", 64'(saw_i_resp), 64'(0));
    d_req_valid = 1'b0;
    run_cycle();
    check("t3_d_resp", 64'(last_d_resp_valid), 64'(1));

    // 4. Kill coincident with the response, with a fresh fetch in the same cycle.
    i_req_valid = 1'b1; i_req_addr = 32'h280;
    next_lat = 2; next_rdata = 32'h1111_1111;
    run_cycle();
    i_req_valid = 1'b0;
    run_cycle();
    i_req_valid = 1'b1; i_req_addr = 32'h300; i_kill = 1'b1;
    next_lat = 2; next_rdata = 32'h2222_2222;
    run_cycle();
    check("t4_old_suppressed", 64'(last_i_resp_valid), 64'(0));
    check("t4_new_ready", 64'(last_i_ready), 64'(1));
    check("t4_new_addr", 64'(last_addr), 64'(32'h300));
    i_req_valid = 1'b0; i_kill = 1'b0;
    run_cycle();
    run_cycle();
    check("t4_new_delivered", 64'(last_i_resp_valid), 64'(1));
    check("t4_new_rdata", 64'(last_i_rdata), 64'(32'h2222_2222));

    // 5. Store with an error response.
    d_req_valid = 1'b1; d_req_addr = 32'h500; d_req_wen = 1'b1; d_req_wdata = 32'h55AA;
    next_lat = 1; next_rdata = '0; next_err = 1'b1; next_errty = 2'd2;
    run_cycle();
    check("t5_wen", 64'(last_wen), 64'(1));
    check("t5_wdata", 64'(last_wdata), 64'(32'h55AA));
    d_req_valid = 1'b0; d_req_wen = 1'b0;
    run_cycle();
    check("t5_d_resp_valid", 64'(last_d_resp_valid), 64'(1));
    check("t5_d_error", 64'(last_d_err), 64'(1));
    check("t5_d_errty", 64'(last_d_errty), 64'(2));
    next_err = 1'b0; next_errty = '0;

    // 6. Reset while a D access is outstanding and the streak is non-zero.
    i_req_valid = 1'b1; d_req_valid = 1'b1; next_lat = 5;
    run_cycle();
    run_cycle();
    do_reset();
    run_cycle();
    check("t6_i_ready", 64'(last_i_ready), 64'(0));
    check("t6_d_ready", 64'(last_d_ready), 64'(0));
    check("t6_mem_req_valid", 64'(last_mvalid), 64'(0));
    check("t6_i_resp_valid", 64'(last_i_resp_valid), 64'(0));
    check("t6_d_resp_valid", 64'(last_d_resp_valid), 64'(0));
    grant_log.delete();
    mem_req_ready = 1'b1; i_req_valid = 1'b1; d_req_valid = 1'b1; next_lat = 1;
    repeat (5) run_cycle();
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    run_cycle();
    check("t6_grant_count", 64'(grant_log.size()), 64'(5));
    for (int k = 0; k < 5 && k < grant_log.size(); k++) begin
      check($sformatf("t6_grant_order[%0d]", k), 64'(grant_log[k]), 64'(exp_order6[k]));
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      i_req_valid   = ($urandom_range(0, 99) < 60);
      d_req_valid   = ($urandom_range(0, 99) < 60);
      i_kill        = ($urandom_range(0, 99) < 12);
      mem_req_ready = ($urandom_range(0, 99) < 75);
      i_req_addr    = $urandom();
      d_req_addr    = $urandom();
      d_req_wen     = 1'($urandom_range(0, 1));
      d_req_wdata   = $urandom();
      next_lat      = int'($urandom_range(1, 4));
      next_rdata    = $urandom();
      next_err      = 1'($urandom_range(0, 1));
      next_errty    = EW'($urandom_range(0, 3));
      run_cycle();
    end

    // Let any outstanding transaction finish, bounded.
    i_req_valid = 1'b0; d_req_valid = 1'b0; i_kill = 1'b0;
    for (int n = 0; n < 10 && owner != OWN_NONE; n++) run_cycle();
    check("final_drained", 64'(owner), 64'(OWN_NONE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
